// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter
//   Shares one combinational 16x16 signed multiplier tree among N_REQ
//   requesters using round-robin arbitration. Operands are registered in
//   front of the tree and the product is registered behind it.
//
// Ports
//   clk, rst_n  : rising-edge clock, synchronous active-low reset
//   req_valid   : per-requester operand pair pending
//   req_x/req_y : flattened signed operands, slice i = [i*W +: W]
//   req_ready   : one-hot (or zero) accept strobe, only asserted in IDLE
//   res_valid   : res_prod/res_id valid, held until res_ready
//   res_ready   : consumer accepts the result
//   res_prod    : full-width signed product x*y
//   res_id      : requester that owns res_prod
//   busy        : an operation is in flight or awaiting hand-off
//   done_cnt    : completed result hand-offs, wraps at 16 bits
module mult_share_arbiter #(
  parameter  int unsigned N_REQ = 4,
  parameter  int unsigned W     = 16,
  localparam int unsigned IDW   = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [N_REQ*W-1:0] req_x,
  input  logic [N_REQ*W-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*W-1:0]     res_prod,
  output logic [IDW-1:0]     res_id,
  output logic               busy,
  output logic [15:0]        done_cnt
);

  typedef enum logic [1:0] {IDLE, MULT, RESULT} state_t;

  state_t         state, state_nx;
  logic           found;
  logic [IDW-1:0] winner;
  logic [IDW-1:0] cand;
  logic [IDW-1:0] last_grant;
  logic [IDW-1:0] op_id;
  logic [W-1:0]   op_x, op_y;
  logic [2*W-1:0] tree_prod;

  // Round-robin search starting just after the last grant.
  always_comb begin : rr_search
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = IDW'((32'(last_grant) + k) % N_REQ);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_ff @(posedge clk) begin : state_reg
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // req_ready depends only on state, req_valid and last_grant.
  always_comb begin : fsm_next
    state_nx  = state;
    req_ready = '0;
    case (state)
      IDLE: begin
        if (found) begin
          req_ready[winner] = 1'b1;
          state_nx          = MULT;
        end
      end
      MULT:    state_nx = RESULT;
      RESULT:  if (res_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Combinational multiplier tree; sign-extended operands keep the low 2W
  // bits equal to the exact signed product.
  assign tree_prod = {{W{op_x[W-1]}}, op_x} * {{W{op_y[W-1]}}, op_y};

  always_ff @(posedge clk) begin : datapath
    if (!rst_n) begin
      op_x       <= '0;
      op_y       <= '0;
      op_id      <= '0;
      last_grant <= IDW'(N_REQ - 1);
      res_valid  <= 1'b0;
      res_prod   <= '0;
      res_id     <= '0;
      done_cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            op_x       <= req_x[32'(winner)*W +: W];
            op_y       <= req_y[32'(winner)*W +: W];
            op_id      <= winner;
            last_grant <= winner;
          end
        end
        MULT: begin
          res_prod  <= tree_prod;
          res_id    <= op_id;
          res_valid <= 1'b1;
        end
        RESULT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            done_cnt  <= done_cnt + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter
//   Directed scenarios plus randomized traffic against a transaction-level
//   model of the shared multiplier; literal expectations pin the model.
module tb_mult_share_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*16-1:0] req_x = '0;
  logic [N*16-1:0] req_y = '0;
  logic [N-1:0]    req_ready;
  logic            res_valid;
  logic            res_ready = 1'b0;
  logic [31:0]     res_prod;
  logic [1:0]      res_id;
  logic            busy;
  logic [15:0]     done_cnt;

  always #5 clk = ~clk;

  mult_share_arbiter #(.N_REQ(N), .W(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_x     (req_x),
    .req_y     (req_y),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_prod  (res_prod),
    .res_id    (res_id),
    .busy      (busy),
    .done_cnt  (done_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model: one job at a time; a job is computing in its first cycle after
  // acceptance and presents its result from then until the hand-off.
  bit          armed = 1'b0;
  bit          m_job = 1'b0;
  int          m_age = 0;
  shortint     m_x, m_y;
  int          m_id = 0;
  int          m_ptr = N - 1;
  int          m_last_prod = 0;
  int          m_last_id = 0;
  logic [15:0] m_done = '0;
  int          grant_log[$];
  int          prod_log[$];
  int          id_log[$];

  function automatic int rr_pick(input logic [N-1:0] v, input int ptr);
    for (int k = 1; k <= N; k++) begin
      if (v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  always @(negedge clk) begin : compare
    logic [N-1:0] exp_ready;
    int w;
    w = m_job ? -1 : rr_pick(req_valid, m_ptr);
    exp_ready = (w >= 0) ? (N'(1) << w) : '0;
    if (armed) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("res_valid", 32'(res_valid), 32'(m_job && m_age >= 1));
      chk("res_prod",  res_prod, m_last_prod);
      chk("res_id",    32'(res_id), m_last_id);
      chk("busy",      32'(busy), 32'(m_job));
      chk("done_cnt",  32'(done_cnt), 32'(m_done));
    end
    if (!rst_n) begin
      armed       = 1'b1;
      m_job       = 1'b0;
      m_ptr       = N - 1;
      m_last_prod = 0;
      m_last_id   = 0;
      m_done      = '0;
    end else if (w >= 0) begin
      m_job = 1'b1;
      m_age = 0;
      m_x   = shortint'(req_x[w*16 +: 16]);
      m_y   = shortint'(req_y[w*16 +: 16]);
      m_id  = w;
      m_ptr = w;
      grant_log.push_back(w);
    end else if (m_job && m_age == 0) begin
      m_age       = 1;
      m_last_prod = int'(m_x) * int'(m_y);
      m_last_id   = m_id;
    end else if (m_job && res_ready) begin
      m_job  = 1'b0;
      m_done = m_done + 16'd1;
      prod_log.push_back(m_last_prod);
      id_log.push_back(m_last_id);
    end
  end

  logic [N-1:0] g;

  // One clock: sample the grant before the edge, drive after it.
  task automatic step();
    @(negedge clk);
    #1 g = req_ready;
    @(posedge clk);
    #1 req_valid = req_valid & ~g;
  endtask

  task automatic do_reset(input int n);
    rst_n     = 1'b0;
    req_valid = '0;
    repeat (n) step();
    rst_n = 1'b1;
  endtask

  task automatic send(input int i, input logic [15:0] x, input logic [15:0] y);
    req_x[i*16 +: 16] = x;
    req_y[i*16 +: 16] = y;
    req_valid[i]      = 1'b1;
  endtask

  task automatic run_idle(input int maxc, input string nm);
    int c = 0;
    while ((req_valid != '0 || m_job) && c < maxc) begin
      step();
      c++;
    end
    chk(nm, 32'(req_valid != '0 || m_job), 32'd0);
  endtask

  task automatic clear_logs();
    grant_log.delete();
    prod_log.delete();
    id_log.delete();
  endtask

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 7))
      0:       return 16'h8000;
      1:       return 16'h7FFF;
      2:       return 16'h0000;
      3:       return 16'hFFFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1);
  end

  initial begin : driver
    int c;
    int exp_grants[4];
    int exp_prods[4];

    // Reset values and idle behaviour.
    do_reset(3);
    repeat (3) step();
    chk("rst_done_cnt",  32'(done_cnt), 32'd0);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy",      32'(busy), 32'd0);
    chk("idle_ready",    32'(req_ready), 32'd0);

    // Single request -4 * 12.
    clear_logs();
    res_ready = 1'b1;
    send(0, 16'hFFFC, 16'd12);
    step();
    chk("t2_grant", 32'(g), 32'd1);
    run_idle(20, "t2_drain");
    chk("t2_count", prod_log.size(), 1);
    if (prod_log.size() >= 1) begin
      chk("t2_prod", prod_log[0], 32'hFFFFFFD0);
      chk("t2_id",   id_log[0], 0);
    end
    chk("t2_done", 32'(done_cnt), 32'd1);

    // All four at once from reset priority.
    do_reset(1);
    clear_logs();
    send(0, 16'hFFCD, 16'd2);
    send(1, 16'd4011, 16'd142);
    send(2, 16'd1011, 16'd15);
    send(3, 16'hFFFF, 16'd1);
    run_idle(40, "t3_drain");
    exp_grants = '{0, 1, 2, 3};
    exp_prods  = '{32'hFFFFFF9A, 32'h0008B0DA, 32'h00003B3D, 32'hFFFFFFFF};
    chk("t3_count", prod_log.size(), 4);
    for (int i = 0; i < 4; i++) begin
      if (i < grant_log.size()) chk("t3_grant", grant_log[i], exp_grants[i]);
      if (i < prod_log.size()) begin
        chk("t3_prod", prod_log[i], exp_prods[i]);
        chk("t3_id",   id_log[i], exp_grants[i]);
      end
    end

    // Backpressure while another requester waits.
    clear_logs();
    res_ready = 1'b0;
    send(0, 16'd7, 16'd8);
    step();
    step();
    send(1, 16'd3, 16'd3);
    repeat (5) begin
      step();
      chk("t4_prod",  res_prod, 32'h38);
      chk("t4_busy",  32'(busy), 32'd1);
      chk("t4_ready", 32'(g), 32'd0);
    end
    res_ready = 1'b1;
    step();
    chk("t4_one_hs", 32'(done_cnt), 32'd5);
    chk("t4_valid",  32'(res_valid), 32'd0);
    run_idle(20, "t4_drain");
    chk("t4_done", 32'(done_cnt), 32'd6);

    // Fairness between two continuously valid requesters.
    do_reset(1);
    clear_logs();
    send(0, rnd16(), rnd16());
    send(2, rnd16(), rnd16());
    c = 0;
    while (grant_log.size() < 8 && c < 60) begin
      step();
      if (g[0]) send(0, rnd16(), rnd16());
      if (g[2]) send(2, rnd16(), rnd16());
      c++;
    end
    req_valid = '0;
    run_idle(20, "t5_drain");
    chk("t5_count", 32'(grant_log.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++) begin
      if (i < grant_log.size()) chk("t5_order", grant_log[i], (i % 2) ? 2 : 0);
    end

    // Reset while a multiply is in flight.
    do_reset(1);
    clear_logs();
    send(0, 16'd3, 16'd5);
    step();
    chk("t6_grant", 32'(g), 32'd1);
    rst_n     = 1'b0;
    req_valid = '0;
    step();
    rst_n = 1'b1;
    chk("t6_valid", 32'(res_valid), 32'd0);
    chk("t6_done",  32'(done_cnt), 32'd0);
    chk("t6_busy",  32'(busy), 32'd0);
    send(0, 16'hFFFC, 16'd12);
    run_idle(20, "t6_drain");
    chk("t6_count", prod_log.size(), 1);
    if (prod_log.size() >= 1) chk("t6_prod", prod_log[0], 32'hFFFFFFD0);
    chk("t6_done2", 32'(done_cnt), 32'd1);

    // Randomized traffic with occasional resets.
    for (int n = 0; n < 600; n++) begin
      res_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) send(i, rnd16(), rnd16());
      end
      rst_n = ($urandom_range(0, 199) != 0);
      if (!rst_n) req_valid = '0;
      step();
      rst_n = 1'b1;
    end
    req_valid = '0;
    res_ready = 1'b1;
    run_idle(20, "rand_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
